// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide unit for the M-extension operations.
// One shift-add (multiply) or restoring-subtract (divide) step per clock, valid/ready on both sides.
module alu_muldiv_iter #(
  parameter int XLEN = 32,
  parameter int CTLW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [CTLW-1:0] ctl,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] res,
  output logic            dz,
  output logic            busy
);

  // Handshake: a request transfers on a rising edge where in_vld && in_rdy;
  // a result transfers on a rising edge where out_vld && out_rdy.

  localparam logic [CTLW-1:0] ALU_CTL_MUL    = CTLW'(32'h0001_0000);
  localparam logic [CTLW-1:0] ALU_CTL_MULH   = CTLW'(32'h0002_0000);
  localparam logic [CTLW-1:0] ALU_CTL_MULHSU = CTLW'(32'h0004_0000);
  localparam logic [CTLW-1:0] ALU_CTL_MULHU  = CTLW'(32'h0008_0000);
  localparam logic [CTLW-1:0] ALU_CTL_DIV    = CTLW'(32'h0010_0000);
  localparam logic [CTLW-1:0] ALU_CTL_DIVU   = CTLW'(32'h0020_0000);
  localparam logic [CTLW-1:0] ALU_CTL_REM    = CTLW'(32'h0040_0000);
  localparam logic [CTLW-1:0] ALU_CTL_REMU   = CTLW'(32'h0080_0000);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  logic [XLEN-1:0]   b, quo, rmd;
  logic [XLEN:0]     opa, sum;
  logic              mul_q, hi_q, rem_q, neg_q;
  logic [XLEN-1:0]   res_q, fin_res;
  logic              dz_q;

  // Request decode
  logic            is_mul, is_div, is_rem, sgn1, sgn2, div_zero, ovf, special, accept;
  logic [XLEN-1:0] mag1, mag2, spec_res;

  always_comb begin
    is_mul   = (ctl == ALU_CTL_MUL) || (ctl == ALU_CTL_MULH) ||
               (ctl == ALU_CTL_MULHSU) || (ctl == ALU_CTL_MULHU);
    is_div   = (ctl == ALU_CTL_DIV) || (ctl == ALU_CTL_DIVU) ||
               (ctl == ALU_CTL_REM) || (ctl == ALU_CTL_REMU);
    is_rem   = (ctl == ALU_CTL_REM) || (ctl == ALU_CTL_REMU);
    sgn1     = ((ctl == ALU_CTL_MULH) || (ctl == ALU_CTL_MULHSU) ||
                (ctl == ALU_CTL_DIV) || (ctl == ALU_CTL_REM)) && op1[XLEN-1];
    sgn2     = ((ctl == ALU_CTL_MULH) || (ctl == ALU_CTL_DIV) ||
                (ctl == ALU_CTL_REM)) && op2[XLEN-1];
    mag1     = sgn1 ? -op1 : op1;
    mag2     = sgn2 ? -op2 : op2;
    div_zero = is_div && (op2 == '0);
    ovf      = ((ctl == ALU_CTL_DIV) || (ctl == ALU_CTL_REM)) && (op1 == SMIN) && (op2 == '1);
    special  = !(is_mul || is_div) || div_zero || ovf;
    spec_res = '0;
    if (div_zero)
      spec_res = is_rem ? op1 : '1;
    else if (ovf)
      spec_res = (ctl == ALU_CTL_DIV) ? op1 : '0;
    accept   = (state == S_IDLE) && in_vld;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_vld) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == LAST) state_nxt = S_DONE;
      S_DONE: if (out_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Shared adder: multiply adds into the upper half; divide trial-subtracts
  // from the upper half shifted left by one with the next dividend bit.
  always_comb begin
    opa     = mul_q ? {1'b0, acc[2*XLEN-1:XLEN]} : acc[2*XLEN-1:XLEN-1];
    sum     = mul_q ? (opa + {1'b0, b}) : (opa - {1'b0, b});
    acc_nxt = '0;
    if (mul_q)
      acc_nxt = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    else
      acc_nxt = !sum[XLEN] ? {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    prod    = neg_q ? -acc_nxt : acc_nxt;
    quo     = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rmd     = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    fin_res = '0;
    if (mul_q)
      fin_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else
      fin_res = rem_q ? rmd : quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      b     <= '0;
      mul_q <= 1'b0;
      hi_q  <= 1'b0;
      rem_q <= 1'b0;
      neg_q <= 1'b0;
      res_q <= '0;
      dz_q  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      acc   <= {{XLEN{1'b0}}, mag1};
      b     <= mag2;
      mul_q <= is_mul;
      hi_q  <= (ctl != ALU_CTL_MUL);
      rem_q <= is_rem;
      neg_q <= (is_rem ? sgn1 : (sgn1 ^ sgn2));
      res_q <= spec_res;
      dz_q  <= div_zero;
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      if (cnt == LAST) res_q <= fin_res;
    end
  end

  assign in_rdy  = (state == S_IDLE) && !rst;
  assign out_vld = (state == S_DONE) && !rst;
  assign busy    = (state != S_IDLE) && !rst;
  assign res     = rst ? '0 : res_q;
  assign dz      = dz_q && !rst;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Directed bench for alu_muldiv_iter: latency, arithmetic, special cases,
// result backpressure and mid-operation reset.
module tb_alu_muldiv_iter;

  localparam logic [23:0] C_MUL    = 24'h01_0000;
  localparam logic [23:0] C_MULH   = 24'h02_0000;
  localparam logic [23:0] C_MULHSU = 24'h04_0000;
  localparam logic [23:0] C_MULHU  = 24'h08_0000;
  localparam logic [23:0] C_DIV    = 24'h10_0000;
  localparam logic [23:0] C_DIVU   = 24'h20_0000;
  localparam logic [23:0] C_REM    = 24'h40_0000;
  localparam logic [23:0] C_REMU   = 24'h80_0000;

  logic        clk = 1'b0;
  logic        rst, in_vld, in_rdy, out_vld, out_rdy, dz, busy;
  logic [23:0] ctl;
  logic [31:0] op1, op2, res;

  int errors = 0;
  int checks = 0;

  alu_muldiv_iter #(.XLEN(32), .CTLW(24)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .ctl(ctl),
    .op1(op1), .op2(op2), .out_vld(out_vld), .out_rdy(out_rdy),
    .res(res), .dz(dz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a falling edge. Consumes the result when out_rdy is high.
  task automatic do_op(input string tag, input logic [23:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r,
                       input logic exp_dz, input int exp_lat);
    int n;
    int lat;
    n = 0;
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, {31'b0, in_rdy}, 32'd1);
    in_vld = 1'b1; ctl = c; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    in_vld = 1'b0; ctl = 24'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2 && exp_lat > 2) begin
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_calc_rdy"}, {31'b0, in_rdy}, 32'd0);
      end
    end while (!out_vld && lat < 100);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, res, exp_r);
    chk({tag, "_dz"}, {31'b0, dz}, {31'b0, exp_dz});
    if (out_rdy) begin
      @(negedge clk);
      chk({tag, "_next_rdy"}, {31'b0, in_rdy}, 32'd1);
      chk({tag, "_vld_drop"}, {31'b0, out_vld}, 32'd0);
    end
  endtask

  initial begin
    logic saw_vld;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; ctl = '0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd0);
    chk("rst_out_vld", {31'b0, out_vld}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_rdy", {31'b0, in_rdy}, 32'd1);

    do_op("mulh",   C_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
    do_op("mulhu",  C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    do_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("mul",    C_MUL,    32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("mul_neg", C_MUL,   32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0, 33);
    do_op("div",    C_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("rem",    C_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33);
    do_op("div_pn", C_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("rem_pn", C_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    do_op("divu",   C_DIVU,   32'h0AE0_2023, 32'h8000_0A12, 32'h0000_0000, 1'b0, 33);
    do_op("remu",   C_REMU,   32'h0AE0_2023, 32'h8000_0A12, 32'h0AE0_2023, 1'b0, 33);
    do_op("divu_s", C_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 33);
    do_op("remu_s", C_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 33);
    do_op("div_z",  C_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1);
    do_op("remu_z", C_REMU,   32'd5,         32'd0,         32'h0000_0005, 1'b1, 1);
    do_op("div_ov", C_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    do_op("rem_ov", C_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1);
    do_op("unk",    24'h00_0001, 32'd9,      32'd3,         32'h0000_0000, 1'b0, 1);

    // Backpressure: result held for 10 cycles while in_vld pulses are ignored
    out_rdy = 1'b0;
    do_op("bp_mul", C_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 33);
    for (int i = 0; i < 10; i++) begin
      in_vld = i[0]; ctl = C_DIVU; op1 = 32'd5; op2 = 32'd0;
      @(negedge clk);
      chk("bp_res_hold", res, 32'h0001_2340);
      chk("bp_in_rdy", {31'b0, in_rdy}, 32'd0);
      chk("bp_out_vld", {31'b0, out_vld}, 32'd1);
    end
    in_vld = 1'b1; ctl = C_DIV; op1 = 32'd5; op2 = 32'd0; out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_vld", {31'b0, out_vld}, 32'd0);
    chk("bp_release_rdy", {31'b0, in_rdy}, 32'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    @(negedge clk);
    chk("bp_next_vld", {31'b0, out_vld}, 32'd1);
    chk("bp_next_res", res, 32'hFFFF_FFFF);
    chk("bp_next_dz", {31'b0, dz}, 32'd1);
    @(negedge clk);
    chk("bp_next_done", {31'b0, in_rdy}, 32'd1);

    // Reset during CALC cycle 12
    in_vld = 1'b1; ctl = C_MUL; op1 = 32'h0000_1234; op2 = 32'h0000_5678;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (12) @(negedge clk);
    chk("rc_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rc_in_rdy", {31'b0, in_rdy}, 32'd0);
    chk("rc_out_vld", {31'b0, out_vld}, 32'd0);
    chk("rc_busy_rst", {31'b0, busy}, 32'd0);
    chk("rc_res", res, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rc_rdy_after", {31'b0, in_rdy}, 32'd1);
    saw_vld = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_vld = saw_vld | out_vld;
    end
    chk("rc_no_vld", {31'b0, saw_vld}, 32'd0);
    do_op("rc_mul", C_MUL, 32'd3, 32'd7, 32'h0000_0015, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
